// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl shared types and constants.
// FSM states, stall-bus patterns, access-size decode.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IF,
    ST_MEM,
    ST_DONE
  } state_t;

  localparam int STALL_W  = 6;
  localparam int NBYTES_W = 3;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  // sizes other than 1 or 2 bytes mean a full word
  function automatic logic [2:0] nbytes_dec(
    input logic [NBYTES_W-1:0] nb
  );
    case (nb)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/pipe_ctrl_ram_byte_seq.sv
// Byte serialiser for the single byte-wide RAM port.
// Walks addr+k, shifts read bytes in, drives store bytes.
module pipe_ctrl_ram_byte_seq #(
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  we,
  input  logic [2:0]            n,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  input  logic [7:0]            ram_din,
  output logic [RAM_ADDR_W-1:0] ram_a,
  output logic                  ram_wr,
  output logic [7:0]            ram_dout,
  output logic                  wr_op,
  output logic                  fin,
  output logic [31:0]           rdata
);

  logic        active;
  logic [2:0]  cnt;
  logic [2:0]  n_r;
  logic [31:0] base;
  logic [31:0] wbuf;
  logic [31:0] cap;
  logic [31:0] nxt_a;
  logic [1:0]  rsel;
  logic [7:0]  wbyte;
  logic        unused_hi;

  assign nxt_a     = base + {29'd0, cnt};
  assign unused_hi = ^nxt_a[31:RAM_ADDR_W];
  assign rsel      = cnt[1:0] - 2'd2;
  assign wbyte     = wbuf[{cnt[1:0], 3'b000} +: 8];

  assign fin = active &&
    (wr_op ? (cnt == n_r) : (cnt == n_r + 3'd1));

  // final read byte merged straight from ram_din
  always_comb begin
    rdata = cap;
    rdata[{rsel, 3'b000} +: 8] = ram_din;
  end

  // byte counter, address walk and capture
  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      cnt      <= 3'd0;
      n_r      <= 3'd0;
      base     <= 32'd0;
      wbuf     <= 32'd0;
      cap      <= 32'd0;
      wr_op    <= 1'b0;
      ram_a    <= '0;
      ram_wr   <= 1'b0;
      ram_dout <= 8'd0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= 3'd1;
      n_r    <= n;
      base   <= addr;
      wbuf   <= wdata;
      cap    <= 32'd0;
      wr_op  <= we;
      ram_a  <= addr[RAM_ADDR_W-1:0];
      ram_wr <= we;
      if (we) ram_dout <= wdata[7:0];
    end else if (abort || fin) begin
      active <= 1'b0;
      cnt    <= 3'd0;
      ram_wr <= 1'b0;
    end else if (active) begin
      cnt <= cnt + 3'd1;
      if (cnt < n_r) begin
        ram_a <= nxt_a[RAM_ADDR_W-1:0];
        if (wr_op) ram_dout <= wbyte;
      end
      if (!wr_op && cnt >= 3'd2)
        cap[{rsel, 3'b000} +: 8] <= ram_din;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: RAM port arbitration and stall bus.
// MEM beats IF; a taken branch cancels fetch.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_done,
  output logic [31:0]           if_inst,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [31:0]           mem_addr,
  input  logic [NBYTES_W-1:0]   mem_nbytes,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_done,
  output logic [31:0]           mem_rdata,
  input  logic                  stallreq_id,
  input  logic                  branch_flag,
  output logic [RAM_ADDR_W-1:0] ram_a,
  output logic                  ram_wr,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din,
  output logic [STALL_W-1:0]    stall
);

  state_t      state;
  logic        grant_mem;
  logic        grant_if;
  logic        start;
  logic        abort;
  logic        fin;
  logic        wr_op;
  logic [31:0] rdata;

  assign grant_mem = (state == ST_IDLE) && mem_req;
  assign grant_if  = (state == ST_IDLE) && !mem_req &&
                     if_req && !branch_flag;
  assign start     = grant_mem || grant_if;
  assign abort     = (state == ST_IF) && branch_flag;

  pipe_ctrl_ram_byte_seq #(
    .RAM_ADDR_W(RAM_ADDR_W)
  ) u_seq (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .we      (grant_mem && mem_we),
    .n       (grant_mem ? nbytes_dec(mem_nbytes) : 3'd4),
    .addr    (grant_mem ? mem_addr : if_addr),
    .wdata   (mem_wdata),
    .ram_din (ram_din),
    .ram_a   (ram_a),
    .ram_wr  (ram_wr),
    .ram_dout(ram_dout),
    .wr_op   (wr_op),
    .fin     (fin),
    .rdata   (rdata)
  );

  // arbitration FSM with registered done pulses and data
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      if_inst   <= 32'd0;
      mem_rdata <= 32'd0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (grant_mem)     state <= ST_MEM;
          else if (grant_if) state <= ST_IF;
        end
        ST_IF: begin
          if (branch_flag) begin
            state <= ST_IDLE;
          end else if (fin) begin
            if_done <= 1'b1;
            if_inst <= rdata;
            state   <= ST_DONE;
          end
        end
        ST_MEM: begin
          if (fin) begin
            mem_done <= 1'b1;
            if (!wr_op) mem_rdata <= rdata;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // stall bus in priority order
  always_comb begin
    stall = STALL_NONE;
    if (rst)
      stall = STALL_NONE;
    else if (mem_req && !mem_done)
      stall = STALL_MEM;
    else if (stallreq_id)
      stall = STALL_ID;
    else if (if_req && !if_done && !branch_flag)
      stall = STALL_IF;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios then random traffic.
// Byte RAM plus transaction-level reference model.
module tb_pipe_ctrl;

  localparam int AW    = 17;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_done;
  logic [31:0]   if_inst;
  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [2:0]    mem_nbytes;
  logic [31:0]   mem_wdata;
  logic          mem_done;
  logic [31:0]   mem_rdata;
  logic          stallreq_id;
  logic          branch_flag;
  logic [AW-1:0] ram_a;
  logic          ram_wr;
  logic [7:0]    ram_dout;
  logic [7:0]    ram_din;
  logic [5:0]    stall;

  always #5 clk = ~clk;

  pipe_ctrl #(.RAM_ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_done    (if_done),
    .if_inst    (if_inst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_nbytes (mem_nbytes),
    .mem_wdata  (mem_wdata),
    .mem_done   (mem_done),
    .mem_rdata  (mem_rdata),
    .stallreq_id(stallreq_id),
    .branch_flag(branch_flag),
    .ram_a      (ram_a),
    .ram_wr     (ram_wr),
    .ram_dout   (ram_dout),
    .ram_din    (ram_din),
    .stall      (stall)
  );

  logic [7:0] ram     [0:DEPTH-1];
  logic [7:0] ref_mem [0:DEPTH-1];

  always @(posedge clk) begin
    ram_din <= ram[ram_a];
    if (ram_wr) ram[ram_a] = ram_dout;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference model: owner 0 none, 1 fetch, 2 mem
  int            m_owner = 0;
  int            m_t = 0;
  int            m_n = 0;
  bit            m_fin = 0;
  bit            m_we = 0;
  logic [31:0]   m_addr = 0;
  logic [31:0]   m_wdata = 0;
  logic [AW-1:0] e_ram_a = 0;
  logic          e_ram_wr = 0;
  logic [7:0]    e_ram_dout = 0;
  logic          e_if_done = 0;
  logic          e_mem_done = 0;
  logic [31:0]   e_if_inst = 0;
  logic [31:0]   e_mem_rdata = 0;

  function automatic int ndec(input logic [2:0] nb);
    return (nb == 3'd1) ? 1 : (nb == 3'd2) ? 2 : 4;
  endfunction

  function automatic logic [5:0] exp_stall();
    if (rst) return 6'b000000;
    if (mem_req && !e_mem_done) return 6'b011111;
    if (stallreq_id) return 6'b000111;
    if (if_req && !e_if_done && !branch_flag) return 6'b000011;
    return 6'b000000;
  endfunction

  task automatic model_step();
    logic [31:0] a;
    logic [31:0] d;
    if (e_ram_wr) ref_mem[e_ram_a] = e_ram_dout;
    e_if_done  = 1'b0;
    e_mem_done = 1'b0;
    if (rst) begin
      m_owner = 0; m_fin = 0;
      e_ram_a = 0; e_ram_wr = 0; e_ram_dout = 0;
      e_if_inst = 0; e_mem_rdata = 0;
    end else if (m_fin) begin
      m_fin = 0;
    end else if (m_owner == 0) begin
      if (mem_req) begin
        m_owner = 2; m_we = mem_we; m_addr = mem_addr;
        m_wdata = mem_wdata; m_n = ndec(mem_nbytes);
      end else if (if_req && !branch_flag) begin
        m_owner = 1; m_we = 0; m_addr = if_addr; m_n = 4;
      end
      if (m_owner != 0) begin
        m_t = 0;
        e_ram_a  = m_addr[AW-1:0];
        e_ram_wr = m_we;
        if (m_we) e_ram_dout = m_wdata[7:0];
      end
    end else begin
      m_t++;
      if (m_owner == 1 && branch_flag) begin
        m_owner = 0;
      end else begin
        if (m_t < m_n) begin
          a = m_addr + 32'(m_t);
          e_ram_a = a[AW-1:0];
          if (m_we) e_ram_dout = 8'(m_wdata >> (8 * m_t));
        end
        if (m_we && m_t == m_n) begin
          e_ram_wr = 0; e_mem_done = 1;
          m_owner = 0; m_fin = 1;
        end else if (!m_we && m_t == m_n + 1) begin
          d = 0;
          for (int k = 0; k < m_n; k++) begin
            a = m_addr + 32'(k);
            d = d | (32'(ref_mem[a[AW-1:0]]) << (8 * k));
          end
          if (m_owner == 1) begin
            e_if_done = 1; e_if_inst = d;
          end else begin
            e_mem_done = 1; e_mem_rdata = d;
          end
          m_owner = 0; m_fin = 1;
        end
      end
    end
  endtask

  // one clock: stall before the edge, registers after it
  task automatic tick();
    #1;
    chk("stall", 32'(stall), 32'(exp_stall()));
    @(posedge clk);
    model_step();
    #1;
    chk("ram_a", 32'(ram_a), 32'(e_ram_a));
    chk("ram_wr", 32'(ram_wr), 32'(e_ram_wr));
    chk("ram_dout", 32'(ram_dout), 32'(e_ram_dout));
    chk("if_done", 32'(if_done), 32'(e_if_done));
    chk("mem_done", 32'(mem_done), 32'(e_mem_done));
    chk("if_inst", if_inst, e_if_inst);
    chk("mem_rdata", mem_rdata, e_mem_rdata);
    @(negedge clk);
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
    ram[a] = d;
    ref_mem[a] = d;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      1:       return $urandom | 32'h0001_FFFC;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [2:0] rand_nb();
    case ($urandom_range(0, 3))
      0:       return 3'd1;
      1:       return 3'd2;
      2:       return 3'd4;
      default: return 3'($urandom_range(0, 7));
    endcase
  endfunction

  initial begin
    logic [7:0]  v;
    logic [31:0] bexp;
    int lat, dn;
    rst = 1; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0;
    mem_addr = 0; mem_nbytes = 0; mem_wdata = 0;
    stallreq_id = 0; branch_flag = 0;
    for (int i = 0; i < DEPTH; i++) begin
      v = 8'($urandom);
      ram[i] = v;
      ref_mem[i] = v;
    end
    poke(17'h100, 8'h13); poke(17'h101, 8'h05);
    poke(17'h102, 8'h00); poke(17'h103, 8'h00);
    poke(17'h1FFFF, 8'hAB); poke(17'h00000, 8'hCD);

    @(negedge clk);
    tick(); tick();
    chk("rst_ram_wr", 32'(ram_wr), 0);
    chk("rst_if_inst", if_inst, 0);
    rst = 0;

    // fetch of 13 05 00 00
    if_req = 1; if_addr = 32'h100;
    #1 chk("fetch_stall", 32'(stall), 32'h03);
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c <= 4) chk("fetch_ram_a", 32'(ram_a), 32'h100 + 32'(c - 1));
      if (if_done) begin lat = c; break; end
    end
    chk("fetch_latency", 32'(lat), 6);
    chk("fetch_inst", if_inst, 32'h0000_0513);
    if_req = 0;
    tick();

    // simultaneous requests, MEM wins and wraps
    if_req = 1; if_addr = 32'h200;
    mem_req = 1; mem_we = 0; mem_nbytes = 3'd2; mem_addr = 32'h0001_FFFF;
    #1 chk("sim_stall", 32'(stall), 32'h1F);
    tick(); chk("sim_a0", 32'(ram_a), 32'h1FFFF);
    tick(); chk("sim_a1", 32'(ram_a), 32'h0);
    for (int c = 0; c < 6 && !mem_done; c++) tick();
    chk("sim_mem_done", 32'(mem_done), 1);
    chk("sim_rdata", mem_rdata, 32'h0000_CDAB);
    mem_req = 0;
    tick(); chk("sim_gap", 32'(ram_a), 32'h0);
    tick(); chk("sim_if_grant", 32'(ram_a), 32'h200);
    for (int c = 0; c < 10 && !if_done; c++) tick();
    chk("sim_if_done", 32'(if_done), 1);
    if_req = 0;
    tick();

    // store word
    bexp = 32'hDEAD_BEEF;
    mem_req = 1; mem_we = 1; mem_nbytes = 3'd4;
    mem_addr = 32'h20; mem_wdata = bexp;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("st_wr", 32'(ram_wr), 1);
      chk("st_a", 32'(ram_a), 32'h20 + 32'(k));
      chk("st_dout", 32'(ram_dout), (bexp >> (8 * k)) & 32'hFF);
    end
    tick();
    chk("st_done", 32'(mem_done), 1);
    chk("st_wr_off", 32'(ram_wr), 0);
    mem_req = 0; mem_we = 0;
    tick();
    chk("st_ram", {ram[17'h23], ram[17'h22], ram[17'h21], ram[17'h20]},
        32'hDEAD_BEEF);

    // branch cancels an in-flight fetch
    if_req = 1; if_addr = 32'h300;
    tick(); tick(); tick();
    branch_flag = 1;
    #1 chk("br_stall", 32'(stall), 32'h00);
    tick();
    branch_flag = 0; if_req = 0;
    dn = 0;
    for (int c = 0; c < 8; c++) begin
      dn += int'(if_done);
      tick();
    end
    chk("br_no_done", 32'(dn), 0);

    // load-use and memory stall priority
    stallreq_id = 1;
    #1 chk("lu_stall", 32'(stall), 32'h07);
    mem_req = 1; mem_we = 0; mem_nbytes = 3'd1; mem_addr = 32'h40;
    #1 chk("lu_mem_stall", 32'(stall), 32'h1F);
    for (int c = 0; c < 8 && !mem_done; c++) tick();
    chk("lu_done", 32'(mem_done), 1);
    mem_req = 0; stallreq_id = 0;
    tick();

    // reset in the middle of a store
    mem_req = 1; mem_we = 1; mem_nbytes = 3'd4;
    mem_addr = 32'h50; mem_wdata = $urandom;
    tick(); tick();
    rst = 1;
    #1 chk("rs_stall", 32'(stall), 32'h00);
    tick();
    chk("rs_wr", 32'(ram_wr), 0);
    chk("rs_done", 32'(mem_done), 0);
    chk("rs_ram_a", 32'(ram_a), 0);
    chk("rs_dout", 32'(ram_dout), 0);
    chk("rs_rdata", mem_rdata, 0);
    rst = 0; mem_req = 0; mem_we = 0;
    tick();

    // random traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (rst) begin
        rst = 0; if_req = 0; mem_req = 0;
      end
      if (e_if_done) if_req = 0;
      else if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1; if_addr = rand_addr();
      end else if (if_req && branch_flag && m_owner != 1)
        if_addr = rand_addr();
      if (e_mem_done) mem_req = 0;
      else if (!mem_req && $urandom_range(0, 5) == 0) begin
        mem_req = 1; mem_we = 1'($urandom);
        mem_nbytes = rand_nb(); mem_addr = rand_addr();
        mem_wdata = $urandom;
      end
      branch_flag = ($urandom_range(0, 9) == 0);
      stallreq_id = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 299) == 0) rst = 1;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
